incdev_inject: RTL

INCDEV_INJECT -- requirements
Module: incdev_inject

---
 rtl/incdev_inject.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/incdev_inject.sv
// Instruction injector: queues debug instructions for a user CPU, offers them to its fetch stage,
// waits for commit or timeout, and replays buffered architectural updates (PC, step, reg write).
module incdev_inject #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_flag,
    input  logic [31:0] ex_inst,
    output logic        ex_finish,
    input  logic        pc_inc,
    input  logic        pc_we,
    input  logic [31:0] pc,
    input  logic        wb_we,
    input  logic [4:0]  wb_wreg,
    input  logic [31:0] wb_wdata,
    output logic        inj_valid,
    output logic [31:0] inj_inst,
    input  logic        inj_ready,
    input  logic        cpu_commit,
    output logic        pc_set,
    output logic [31:0] pc_set_val,
    output logic        pc_step,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        busy,
    output logic        ovf_err,
    output logic        to_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
    localparam logic [7:0]    ToCnt   = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e        state_q;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    wait_q;

    logic          wb_pend_q, pc_pend_q;
    logic [4:0]    wb_reg_q;
    logic [31:0]   wb_data_q, pc_val_q;
    logic [3:0]    step_q, step_d, step_base;

    logic          ex_finish_q, pc_set_q, pc_step_q, rf_we_q, ovf_err_q, to_err_q;
    logic [31:0]   pc_set_val_q, rf_wdata_q;
    logic [4:0]    rf_waddr_q;

    logic full, push, pop, drop;
    logic in_idle, arch_pend, rel_wb, rel_pc, rel_step, wb_ovf, step_ovf;

    assign full = (count_q == FullCnt);
    assign pop  = (state_q == StIssue) && inj_ready;
    assign push = ex_flag && (!full || pop);
    assign drop = ex_flag && full && !pop;

    // Releases only look at already-latched state, so a same-cycle arrival waits one cycle.
    assign in_idle   = (state_q == StIdle);
    assign arch_pend = wb_pend_q || pc_pend_q || (step_q != 4'd0);
    assign rel_wb    = in_idle && wb_pend_q;
    assign rel_pc    = in_idle && pc_pend_q;
    assign rel_step  = in_idle && !wb_pend_q && !pc_pend_q && (step_q != 4'd0);
    assign wb_ovf    = wb_we && wb_pend_q && !rel_wb;

    always_comb begin
        step_base = step_q;
        if (rel_pc) begin
            step_base = 4'd0;
        end else if (rel_step) begin
            step_base = step_q - 4'd1;
        end
        step_d   = step_base;
        step_ovf = 1'b0;
        if (pc_inc) begin
            if (step_base == 4'hF) begin
                step_ovf = 1'b1;
            end else begin
                step_d = step_base + 4'd1;
            end
        end
    end

    // Storage needs no reset; the head is gated onto inj_inst only while offered.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= ex_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            wait_q       <= '0;
            wb_pend_q    <= 1'b0;
            wb_reg_q     <= '0;
            wb_data_q    <= '0;
            pc_pend_q    <= 1'b0;
            pc_val_q     <= '0;
            step_q       <= '0;
            ex_finish_q  <= 1'b0;
            pc_set_q     <= 1'b0;
            pc_set_val_q <= '0;
            pc_step_q    <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            ovf_err_q    <= 1'b0;
            to_err_q     <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);

            if (wb_we) begin
                wb_pend_q <= 1'b1;
                wb_reg_q  <= wb_wreg;
                wb_data_q <= wb_wdata;
            end else if (rel_wb) begin
                wb_pend_q <= 1'b0;
            end
            if (pc_we) begin
                pc_pend_q <= 1'b1;
                pc_val_q  <= pc;
            end else if (rel_pc) begin
                pc_pend_q <= 1'b0;
            end
            step_q <= step_d;

            rf_we_q <= rel_wb;
            if (rel_wb) begin
                rf_waddr_q <= wb_reg_q;
                rf_wdata_q <= wb_data_q;
            end
            pc_set_q <= rel_pc;
            if (rel_pc) pc_set_val_q <= pc_val_q;
            pc_step_q <= rel_step;

            if (drop || wb_ovf || step_ovf) ovf_err_q <= 1'b1;

            ex_finish_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!arch_pend && count_q != '0) state_q <= StIssue;
                end
                StIssue: begin
                    if (inj_ready) begin
                        state_q <= StWait;
                        wait_q  <= '0;
                    end
                end
                StWait: begin
                    if (cpu_commit) begin
                        ex_finish_q <= 1'b1;
                        state_q     <= StIdle;
                    end else if (wait_q == ToCnt) begin
                        to_err_q    <= 1'b1;
                        ex_finish_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign inj_valid  = (state_q == StIssue);
    assign inj_inst   = inj_valid ? mem_q[rptr_q] : 32'd0;
    assign ex_finish  = ex_finish_q;
    assign pc_set     = pc_set_q;
    assign pc_set_val = pc_set_val_q;
    assign pc_step    = pc_step_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign ovf_err    = ovf_err_q;
    assign to_err     = to_err_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

endmodule
